modscale_arbiter: RTL and testbench

Shares one CORDIC scale-factor multiplier among several requesters, such as per-sensor CORDIC vectoring engines that each produce a final X component. It round-robin arbitrates between requesters and registers the selected operand. It then computes MODUL = (XF × 622) >>> 10 (scale constant 0.607252935 in 0Q10) and presents the result with the requester's ID on a valid/ready output port. It sits between the CORDIC engines and the modulus consumer (averaging/output formatting).

---
 rtl/modscale_arbiter.sv | 153 +++++++++++++++
 tb/tb_modscale_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/modscale_arbiter.sv
// Round-robin arbiter in front of a single shared CORDIC scale-factor multiplier.
// Result = (xf * SCALE) >>> 10, returned with the winning requester's ID on a valid/ready port.
module modscale_arbiter #(
    parameter int          NREQ  = 4,
    parameter int          IDW   = 2,
    parameter logic [25:0] SCALE = 26'd622
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_xf,
    output logic [NREQ-1:0]      req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [15:0]          res_data,
    output logic [IDW-1:0]       res_id,
    output logic                 busy,
    output logic [15:0]          op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [15:0]     op_q, op_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            res_valid_q, res_valid_d;
    logic [15:0]     res_data_q, res_data_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic            busy_q, busy_d;
    logic [15:0]     op_count_q, op_count_d;

    logic            grant_found_s;
    logic [IDW-1:0]  grant_idx_s;
    logic [IDW-1:0]  cand_s;
    logic [15:0]     op_sel_s;
    logic [NREQ-1:0] req_ready_s;
    logic signed [25:0] op_ext_s;
    logic signed [25:0] product_s;
    logic [15:0]     scaled_s;

    // Round-robin search starting at ptr, plus operand mux for the winner.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        op_sel_s      = 16'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = IDW'((int'(ptr_q) + k) % NREQ);
            if (!grant_found_s && req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx_s == IDW'(i)) begin
                op_sel_s = req_xf[16*i +: 16];
            end else begin
                op_sel_s = op_sel_s;
            end
        end
    end

    // Sign-extended multiply; the arithmetic shift floors toward minus infinity.
    assign op_ext_s  = {{10{op_q[15]}}, op_q};
    assign product_s = op_ext_s * $signed(SCALE);
    assign scaled_s  = 16'(product_s >>> 10);

    // FSM next-state, grant and datapath updates.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_d        = op_q;
        id_d        = id_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        op_count_d  = op_count_q;
        req_ready_s = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    req_ready_s[grant_idx_s] = 1'b1;
                    op_d    = op_sel_s;
                    id_d    = grant_idx_s;
                    ptr_d   = (grant_idx_s == IDW'(NREQ - 1)) ? '0 : grant_idx_s + IDW'(1);
                    state_d = ST_MULT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MULT: begin
                res_data_d  = scaled_s;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    op_count_d  = op_count_q + 16'd1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            op_q        <= 16'd0;
            id_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= 16'd0;
            res_id_q    <= '0;
            busy_q      <= 1'b0;
            op_count_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_q        <= op_d;
            id_q        <= id_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            busy_q      <= busy_d;
            op_count_q  <= op_count_d;
        end
    end

    assign req_ready = req_ready_s;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = busy_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_modscale_arbiter.sv
// Directed bench for modscale_arbiter: hand-computed results, grant order, backpressure, reset, wrap.
module tb_modscale_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [63:0]  req_xf;
    logic [3:0]   req_ready;
    logic         res_valid;
    logic         res_ready;
    logic [15:0]  res_data;
    logic [1:0]   res_id;
    logic         busy;
    logic [15:0]  op_count;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [15:0]  exp_count;

    modscale_arbiter #(.NREQ(4), .IDW(2), .SCALE(26'd622)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_xf    (req_xf),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'b0000;
        res_ready = 1'b0;
        tick();
        tick();
        reset     = 1'b0;
        exp_count = 16'd0;
    endtask

    // One complete transaction with a single requester and res_ready held high.
    task automatic run_one(input int id, input logic [15:0] xf, input logic [15:0] exp);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        req_valid = oh;
        req_xf[16*id +: 16] = xf;
        res_ready = 1'b1;
        #1;
        check("grant", {28'd0, req_ready}, {28'd0, oh});
        tick();
        req_valid = 4'b0000;
        #1;
        check("mult_busy", {31'd0, busy}, 32'd1);
        check("mult_ready", {28'd0, req_ready}, 32'd0);
        check("mult_valid", {31'd0, res_valid}, 32'd0);
        tick();
        check("done_valid", {31'd0, res_valid}, 32'd1);
        check("done_data", {16'd0, res_data}, {16'd0, exp});
        check("done_id", {30'd0, res_id}, 32'(id));
        tick();
        exp_count = exp_count + 16'd1;
        check("hs_valid", {31'd0, res_valid}, 32'd0);
        check("hs_busy", {31'd0, busy}, 32'd0);
        check("hs_count", {16'd0, op_count}, {16'd0, exp_count});
    endtask

    logic [15:0] rr_exp_data [4];

    initial begin
        reset     = 1'b1;
        req_valid = 4'b0000;
        req_xf    = 64'd0;
        res_ready = 1'b0;
        do_reset();
        #1;
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_data", {16'd0, res_data}, 32'd0);
        check("rst_id", {30'd0, res_id}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_count", {16'd0, op_count}, 32'd0);
        check("rst_ready", {28'd0, req_ready}, 32'd0);

        // Scaling: hand-computed floor((xf*622)/1024).
        run_one(0, 16'd1000, 16'd607);
        run_one(1, -16'sd1000, -16'sd608);
        run_one(2, 16'sd32767, 16'sd19903);
        run_one(3, -16'sd32768, -16'sd19904);
        run_one(0, 16'd0, 16'd0);

        // Round robin with all four requesting continuously.
        do_reset();
        req_xf = {16'd400, 16'd300, 16'd200, 16'd100};
        rr_exp_data[0] = 16'd60;
        rr_exp_data[1] = 16'd121;
        rr_exp_data[2] = 16'd182;
        rr_exp_data[3] = 16'd242;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (g % 4);
            check("rr_grant", {28'd0, req_ready}, {28'd0, oh});
            tick();
            tick();
            check("rr_id", {30'd0, res_id}, 32'(g % 4));
            check("rr_data", {16'd0, res_data}, {16'd0, rr_exp_data[g % 4]});
            tick();
            exp_count = exp_count + 16'd1;
        end
        check("rr_count", {16'd0, op_count}, {16'd0, exp_count});

        // Grant to 2, then with only 1 and 3 pending the pointer favours 3, then wraps to 1.
        req_valid = 4'b0100;
        #1;
        check("rr_g2", {28'd0, req_ready}, 32'h4);
        tick(); tick(); tick();
        exp_count = exp_count + 16'd1;
        req_valid = 4'b1010;
        #1;
        check("rr_g3", {28'd0, req_ready}, 32'h8);
        tick(); tick(); tick();
        exp_count = exp_count + 16'd1;
        check("rr_g1", {28'd0, req_ready}, 32'h2);
        tick(); tick(); tick();
        exp_count = exp_count + 16'd1;
        req_valid = 4'b0000;
        check("rr_count2", {16'd0, op_count}, {16'd0, exp_count});

        // Backpressure: result must hold while res_ready is low.
        req_xf[15:0] = 16'd1000;
        req_valid = 4'b0001;
        res_ready = 1'b0;
        #1;
        tick();
        req_valid = 4'b1111;
        tick();
        check("bp_valid0", {31'd0, res_valid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_valid", {31'd0, res_valid}, 32'd1);
            check("bp_data", {16'd0, res_data}, 32'd607);
            check("bp_id", {30'd0, res_id}, 32'd0);
            check("bp_ready", {28'd0, req_ready}, 32'd0);
            check("bp_busy", {31'd0, busy}, 32'd1);
        end
        res_ready = 1'b1;
        tick();
        req_valid = 4'b0000;
        exp_count = exp_count + 16'd1;
        check("bp_rel_valid", {31'd0, res_valid}, 32'd0);
        check("bp_rel_busy", {31'd0, busy}, 32'd0);
        check("bp_rel_count", {16'd0, op_count}, {16'd0, exp_count});
        tick();
        check("bp_once", {16'd0, op_count}, {16'd0, exp_count});

        // Reset while in MULT.
        req_xf[47:32] = 16'sd32767;
        req_valid = 4'b0100;
        res_ready = 1'b0;
        #1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_count = 16'd0;
        req_valid = 4'b1111;
        #1;
        check("rm_valid", {31'd0, res_valid}, 32'd0);
        check("rm_busy", {31'd0, busy}, 32'd0);
        check("rm_count", {16'd0, op_count}, 32'd0);
        check("rm_ptr", {28'd0, req_ready}, 32'h1);
        req_valid = 4'b0000;

        // Reset while in DONE; res_ready high in that cycle must not count.
        run_one(1, 16'd1000, 16'd607);
        req_valid = 4'b0100;
        res_ready = 1'b0;
        #1;
        tick();
        req_valid = 4'b0000;
        tick();
        check("rd_pre_valid", {31'd0, res_valid}, 32'd1);
        reset = 1'b1;
        res_ready = 1'b1;
        tick();
        reset = 1'b0;
        exp_count = 16'd0;
        req_valid = 4'b1111;
        #1;
        check("rd_valid", {31'd0, res_valid}, 32'd0);
        check("rd_busy", {31'd0, busy}, 32'd0);
        check("rd_count", {16'd0, op_count}, 32'd0);
        check("rd_ptr", {28'd0, req_ready}, 32'h1);
        req_valid = 4'b0000;
        tick();
        check("rd_count2", {16'd0, op_count}, 32'd0);

        // Counter wrap from a preloaded value.
        force dut.op_count_q = 16'hFFFE;
        #1;
        release dut.op_count_q;
        exp_count = 16'hFFFE;
        run_one(2, 16'd1000, 16'd607);
        run_one(3, 16'd1000, 16'd607);
        check("wrap_zero", {16'd0, op_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
